// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- drives the select line of a downstream 2:1 mux, samples
// the mux output once per select value after a settle delay, and presents
// the two samples as a 2-bit frame through a valid/ready handshake.
//
// Parameters:
//   SETTLE     clk cycles sel is held before each sample (1..15)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      single-cycle request to begin one scan frame
//   y_in       downstream mux output
//   out_ready  consumer accepts the frame when high with out_valid
//   sel        mux select (0 = input a, 1 = input b)
//   busy       high whenever the controller is not idle
//   out_valid  frame available on out_data
//   out_data   bit0 = sample with sel=0, bit1 = sample with sel=1
//   frame_cnt  frames accepted by the consumer, wraps 255->0
// Build option:
//   SCAN_CONT_EN  when defined, an accepted frame immediately starts the next
//                 scan instead of returning to idle.

module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  input  logic       out_ready,
  output logic       sel,
  output logic       busy,
  output logic       out_valid,
  output logic [1:0] out_data,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SET0, SET1, HOLD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       shadow;
  logic       settled;

  assign settled = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)     state_nxt = SET0;
      SET0: if (settled)   state_nxt = SET1;
      SET1: if (settled)   state_nxt = HOLD;
      HOLD: if (out_ready) begin
`ifdef SCAN_CONT_EN
        state_nxt = SET0;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode from registered state only, so no input reaches an
  // output combinationally.
  always_comb begin
    sel       = (state == SET1) || (state == HOLD);
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
  end

  // The sel=0 sample waits in shadow so out_data only changes at the single
  // SET1 capture edge and stays stable through HOLD and after transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shadow    <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) cnt <= '0;
        SET0: begin
          if (settled) begin
            shadow <= y_in;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SET1: begin
          if (settled) begin
            out_data <= {y_in, shadow};
            cnt      <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            frame_cnt <= frame_cnt + 8'd1;
            cnt       <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: models the downstream 2:1 mux, issues directed
// frames, and checks accepted frames against a queue of expected values.
// Define SCAN_CONT_EN to exercise the continuous-scan build.

module tb_mux_scan_ctrl;

`ifdef SCAN_CONT_EN
  localparam int unsigned S = 1;
`else
  localparam int unsigned S = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       y_in;
  logic       sel, busy, out_valid;
  logic [1:0] out_data;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign y_in = sel ? b : a;

  mux_scan_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .out_ready(out_ready),
    .sel(sel), .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue start with the given mux inputs and run up to HOLD (edge 4).
  task automatic frame(input logic av, input logic bv);
    a = av;
    b = bv;
    exp_q.push_back({bv, av});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    fork
      // Monitor: every accepted frame is compared against the queue head.
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q.delete();
          exp_cnt = 0;
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got data %0d with no frame expected at %0t",
                     out_data, $time);
          end else begin
            chk("frame_data", out_data, exp_q.pop_front());
          end
          chk("frame_cnt_pre", frame_cnt, exp_cnt);
          exp_cnt = (exp_cnt + 1) % 256;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    tick(2);
    rst = 1'b0;
    check_reset_vals("reset");

`ifdef SCAN_CONT_EN
    begin
      logic [1:0] pat [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 6; n++) begin
        a = pat[n][0];
        b = pat[n][1];
        exp_q.push_back({b, a});
        chk("cont_sel0", sel, 0);
        tick();
        chk("cont_sel1", sel, 1);
        tick();
        chk("cont_valid", out_valid, 1);
        chk("cont_data", out_data, {b, a});
        tick();
        chk("cont_rescan", out_valid, 0);
        chk("cont_busy", busy, 1);
        chk("cont_cnt", frame_cnt, n + 1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("cont_rst");
    end
`else
    // Basic frame, a=1 b=0, consumer always ready.
    out_ready = 1'b1;
    a = 1'b1;
    b = 1'b0;
    exp_q.push_back(2'b01);
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    chk("f1_busy_e0", busy, 1);
    chk("f1_sel_e0", sel, 0);
    tick();                       // edge 1
    chk("f1_sel_e1", sel, 0);
    tick();                       // edge 2
    chk("f1_sel_e2", sel, 1);
    chk("f1_valid_e2", out_valid, 0);
    tick();                       // edge 3
    chk("f1_valid_e3", out_valid, 0);
    tick();                       // edge 4
    chk("f1_valid_e4", out_valid, 1);
    chk("f1_data_e4", out_data, 2'b01);
    chk("f1_cnt_e4", frame_cnt, 0);
    tick();                       // edge 5: transfer
    chk("f1_cnt_e5", frame_cnt, 1);
    chk("f1_busy_e5", busy, 0);
    chk("f1_valid_e5", out_valid, 0);

    // Consumer stalls 10 cycles, a=0 b=1.
    out_ready = 1'b0;
    frame(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 2'b10);
      chk("stall_cnt", frame_cnt, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_cnt_after", frame_cnt, 2);
    chk("stall_busy_after", busy, 0);
    chk("data_retained", out_data, 2'b10);

    // Ready while idle does nothing.
    tick(3);
    chk("idle_ready_cnt", frame_cnt, 2);
    chk("idle_ready_valid", out_valid, 0);

    // Start pulses during a scan are ignored.
    a = 1'b1;
    b = 1'b1;
    exp_q.push_back(2'b11);
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    tick();                       // edge 1
    start = 1'b1;
    tick();                       // edge 2
    start = 1'b0;
    tick();                       // edge 3
    start = 1'b1;
    tick();                       // edge 4
    start = 1'b0;
    chk("ign_valid", out_valid, 1);
    chk("ign_data", out_data, 2'b11);
    tick();                       // edge 5: transfer
    tick(6);
    chk("ign_busy", busy, 0);
    chk("ign_cnt", frame_cnt, 3);

    // Reset mid-scan (in SET1), then a clean frame.
    a = 1'b1;
    b = 1'b0;
    exp_q.push_back(2'b01);
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    tick(2);                      // edges 1-2
    chk("abort_sel", sel, 1);
    rst = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();                       // edge 3
    rst = 1'b0;
    start = 1'b0;
    check_reset_vals("abort");
    frame(1'b0, 1'b0);
    chk("post_abort_valid", out_valid, 1);
    chk("post_abort_data", out_data, 2'b00);
    tick();
    chk("post_abort_cnt", frame_cnt, 1);

    // 256 frames from zero: frame_cnt wraps back to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      frame(iv[0], iv[1]);
      tick();
      if (i == 254) chk("wrap_cnt_255", frame_cnt, 255);
    end
    chk("wrap_cnt_0", frame_cnt, 0);
    chk("wrap_queue_empty", exp_q.size(), 0);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
